// File: rtl/vga_pkg.sv
// vga_pkg: default 800x600@60 timing constants and the bundled timing bus carried by delay stages
package vga_pkg;
  localparam int H_ACTIVE = 800;
  localparam int H_FP = 40;
  localparam int H_SYNC = 128;
  localparam int H_BP = 88;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_ACTIVE = 600;
  localparam int V_FP = 1;
  localparam int V_SYNC = 4;
  localparam int V_BP = 23;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HSYNC_POL = 1'b1;
  localparam logic VSYNC_POL = 1'b1;
  localparam int CW = 11;
  typedef struct packed {
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hsync;
    logic          vsync;
    logic          hblnk;
    logic          vblnk;
  } vga_bus_t;
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: CW-bit enabled counter wrapping to 0 at LAST, exposing its next value and terminal count
module vga_wrap_counter #(
  parameter int            CW   = vga_pkg::CW,
  parameter logic [CW-1:0] LAST = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] q,
  output logic [CW-1:0] nxt,
  output logic          tc
);
  // ">=" lets any out-of-range value recover by wrapping to 0
  assign tc  = q >= LAST;
  assign nxt = en ? (tc ? '0 : q + 1'b1) : q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else q <= nxt;
endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster generator with counts, sync, blanking and frame pulse
// Define VGA_FRAME_CNT_EN to build the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE  = vga_pkg::H_ACTIVE,
  parameter int   H_FP      = vga_pkg::H_FP,
  parameter int   H_SYNC    = vga_pkg::H_SYNC,
  parameter int   H_BP      = vga_pkg::H_BP,
  parameter int   V_ACTIVE  = vga_pkg::V_ACTIVE,
  parameter int   V_FP      = vga_pkg::V_FP,
  parameter int   V_SYNC    = vga_pkg::V_SYNC,
  parameter int   V_BP      = vga_pkg::V_BP,
  parameter logic HSYNC_POL = vga_pkg::HSYNC_POL,
  parameter logic VSYNC_POL = vga_pkg::VSYNC_POL,
  parameter int   CW        = vga_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
  localparam logic [CW-1:0] H_BLK  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SOFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST = CW'(VT - 1);
  localparam logic [CW-1:0] V_BLK  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SON  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SOFF = CW'(V_ACTIVE + V_FP + V_SYNC);
  logic [CW-1:0] h_nxt, v_nxt;
  logic          h_tc, v_tc, wrap;
  vga_wrap_counter #(.CW(CW), .LAST(H_LAST)) u_h (
    .clk, .rst_n, .en(ce), .q(hcount), .nxt(h_nxt), .tc(h_tc)
  );
  vga_wrap_counter #(.CW(CW), .LAST(V_LAST)) u_v (
    .clk, .rst_n, .en(ce & h_tc), .q(vcount), .nxt(v_nxt), .tc(v_tc)
  );
  assign wrap = ce & h_tc & v_tc;
  // Decoding the next counts keeps sync/blank registered in lockstep with the counters
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (h_nxt >= H_SON && h_nxt < H_SOFF) ? HSYNC_POL : ~HSYNC_POL;
      vsync       <= (v_nxt >= V_SON && v_nxt < V_SOFF) ? VSYNC_POL : ~VSYNC_POL;
      hblnk       <= h_nxt >= H_BLK;
      vblnk       <= v_nxt >= V_BLK;
      frame_start <= wrap;
    end
`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) frame_cnt <= '0;
    else if (wrap) frame_cnt <= frame_cnt + 16'd1;
`else
  assign frame_cnt = '0;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks on a default 800x600 instance and a tiny-raster instance for frame-level behaviour
module tb_vga_timing;
  logic clk = 1'b0;
  logic rst_d_n, ce_d, rst_s_n, ce_s;
  logic [10:0] d_h, d_v;
  logic d_hs, d_vs, d_hb, d_vb, d_fs;
  logic [15:0] d_fc;
  logic [3:0] s_h, s_v;
  logic s_hs, s_vs, s_hb, s_vb, s_fs;
  logic [15:0] s_fc;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  vga_timing u_d (
    .clk(clk), .rst_n(rst_d_n), .ce(ce_d), .hcount(d_h), .vcount(d_v), .hsync(d_hs),
    .vsync(d_vs), .hblnk(d_hb), .vblnk(d_vb), .frame_start(d_fs), .frame_cnt(d_fc)
  );
  // 15 x 10 raster: H 8/2/3/2, V 6/1/2/1, so one frame is 150 ce cycles
  vga_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .CW(4)
  ) u_s (
    .clk(clk), .rst_n(rst_s_n), .ce(ce_s), .hcount(s_h), .vcount(s_v), .hsync(s_hs),
    .vsync(s_vs), .hblnk(s_hb), .vblnk(s_vb), .frame_start(s_fs), .frame_cnt(s_fc)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int hs_cnt, fs_cnt, vs_cnt, vb_cnt, first, second, dbl, hold_err;
    logic [3:0] prev_h;
    logic prev_fs;
    rst_d_n = 0; ce_d = 0; rst_s_n = 0; ce_s = 0;
    repeat (3) tick();
    chk("rst_h", d_h, 0);
    chk("rst_v", d_v, 0);
    chk("rst_hs", d_hs, 0);
    chk("rst_vs", d_vs, 0);
    chk("rst_hb", d_hb, 0);
    chk("rst_vb", d_vb, 0);
    chk("rst_fs", d_fs, 0);
    chk("rst_fc", d_fc, 0);
    rst_d_n = 1; ce_d = 1;
    hs_cnt = 0;
    for (int i = 1; i <= 1056; i++) begin
      tick();
      if (d_hs) hs_cnt++;
      if (i == 799) chk("hb_799", d_hb, 0);
      if (i == 800) chk("hb_800", d_hb, 1);
      if (i == 839) chk("hs_839", d_hs, 0);
      if (i == 840) chk("hs_840", d_hs, 1);
      if (i == 967) chk("hs_967", d_hs, 1);
      if (i == 968) chk("hs_968", d_hs, 0);
      if (i == 1055) begin
        chk("h_1055", d_h, 1055);
        chk("v_line0", d_v, 0);
      end
    end
    chk("h_wrap", d_h, 0);
    chk("v_wrap", d_v, 1);
    chk("hb_wrap", d_hb, 0);
    chk("fs_line", d_fs, 0);
    chk("hs_width", hs_cnt, 128);
    repeat (500) tick();
    chk("h_mid", d_h, 500);
    #3 rst_d_n = 0;
    #1;
    chk("async_h", d_h, 0);
    chk("async_v", d_v, 0);
    chk("async_hb", d_hb, 0);
    rst_d_n = 1; ce_d = 0;
    tick();
    chk("rel_hold", d_h, 0);
    ce_d = 1;
    tick();
    chk("rel_run", d_h, 1);
    rst_s_n = 1; ce_s = 1;
    fs_cnt = 0; vs_cnt = 0; vb_cnt = 0;
    for (int i = 1; i <= 150; i++) begin
      tick();
      if (s_fs) fs_cnt++;
      if (s_vs) vs_cnt++;
      if (s_vb) vb_cnt++;
      if (i == 104) begin
        chk("s_vs_104", s_vs, 0);
        chk("s_v_104", s_v, 6);
      end
      if (i == 105) begin
        chk("s_vs_105", s_vs, 1);
        chk("s_h_105", s_h, 0);
        chk("s_v_105", s_v, 7);
      end
      if (i == 149) begin
        chk("s_h_last", s_h, 14);
        chk("s_v_last", s_v, 9);
        chk("s_fs_149", s_fs, 0);
      end
      if (i == 150) begin
        chk("s_h_00", s_h, 0);
        chk("s_v_00", s_v, 0);
        chk("s_fs_150", s_fs, 1);
      end
    end
    chk("s_fs_cnt", fs_cnt, 1);
    chk("s_vs_cnt", vs_cnt, 30);
    chk("s_vb_cnt", vb_cnt, 60);
    tick();
    chk("s_fs_151", s_fs, 0);
    #3 rst_s_n = 0;
    #1;
    chk("s_async_v", s_v, 0);
    chk("s_async_h", s_h, 0);
    rst_s_n = 1;
    first = 0; second = 0; dbl = 0; hold_err = 0; prev_h = 0; prev_fs = 0;
    for (int i = 1; i <= 600; i++) begin
      ce_s = (i % 2 == 1);
      tick();
      if (s_fs) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
      if (s_fs && prev_fs) dbl++;
      if (!ce_s && s_h != prev_h) hold_err++;
      prev_h = s_h;
      prev_fs = s_fs;
    end
    chk("ce_first_fs", first, 299);
    chk("ce_second_fs", second, 599);
    chk("ce_fs_double", dbl, 0);
    chk("ce_hold", hold_err, 0);
    rst_s_n = 0; ce_s = 1;
    tick();
    rst_s_n = 1;
    repeat (450) tick();
`ifdef VGA_FRAME_CNT_EN
    chk("frame_cnt_3", s_fc, 3);
`else
    chk("frame_cnt_off", s_fc, 0);
`endif
    chk("fc_fs", s_fs, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
